// File: rtl/pic_pkg.sv
// Shared constants for the port pin-side logic: OPTION bit positions, port widths
// and the event-arming state encoding.
package pic_pkg;

  localparam int OPT_RBPU_N = 7;
  localparam int OPT_INTEDG = 6;

  localparam int RA_W = 4;
  localparam int RB_W = 8;

  typedef enum logic {
    ARMING = 1'b0,
    ARMED  = 1'b1
  } arm_state_t;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for asynchronous pin inputs; one chain per bit,
// cleared by the active-low asynchronous reset.
module pin_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/port_io_ctrl.sv
// Pin-side PORTA/PORTB controller: output latches, synchronised read path,
// RB0/INT edge and RB7:4 change event pulses.
//
// state  | meaning
// ARMING | synchronisers filling after reset; no event pulses
// ARMED  | snapshot/rb0_prev valid; INT and RB-change detection live
module port_io_ctrl
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ARM_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PORTA_wr,
  input  logic            PORTB_wr,
  input  logic            PORTB_rd,
  input  logic [7:0]      W,
  input  logic [RA_W-1:0] TRISA,
  input  logic [RB_W-1:0] TRISB,
  input  logic [7:0]      OPTION,
  input  logic [RA_W-1:0] RA_in,
  input  logic [RB_W-1:0] RB_in,
  output logic [RA_W-1:0] RA_out,
  output logic [RA_W-1:0] RA_oe,
  output logic [RB_W-1:0] RB_out,
  output logic [RB_W-1:0] RB_oe,
  output logic [RB_W-1:0] RB_pu,
  output logic [RA_W-1:0] PORTA_q,
  output logic [RB_W-1:0] PORTB_q,
  output logic            INTF_set,
  output logic            RBIF_set
);

  localparam int CNT_W = $clog2(ARM_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ARM_CYCLES - 1);

  arm_state_t       state, state_nxt;
  logic             arm_done;
  logic [CNT_W-1:0] arm_cnt;
  logic [3:0]       snapshot;
  logic [3:0]       trisb_hi_prev;
  logic             rb0_prev;
  logic             mismatch_prev;
  logic [3:0]       newly_input;
  logic [3:0]       mismatch;
  logic             int_edge;
  logic             unused_bits;

  assign unused_bits = ^{OPTION[5:0], TRISB[3:1]};

  assign RA_oe = ~TRISA;
  assign RB_oe = ~TRISB;
  assign RB_pu = OPTION[OPT_RBPU_N] ? '0 : TRISB;

  pin_sync #(.WIDTH(RA_W), .STAGES(SYNC_STAGES)) u_sync_ra (
    .clk (clk), .rst (rst), .d (RA_in), .q (PORTA_q)
  );

  pin_sync #(.WIDTH(RB_W), .STAGES(SYNC_STAGES)) u_sync_rb (
    .clk (clk), .rst (rst), .d (RB_in), .q (PORTB_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RA_out <= '0;
      RB_out <= '0;
    end else begin
      if (PORTA_wr) RA_out <= W[RA_W-1:0];
      if (PORTB_wr) RB_out <= W[RB_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARMING;
      arm_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARMING) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    arm_done  = 1'b0;
    case (state)
      ARMING: if (arm_cnt == CNT_LAST) begin
        state_nxt = ARMED;
        arm_done  = 1'b1;
      end
      ARMED: state_nxt = ARMED;
      default: state_nxt = ARMING;
    endcase
  end

  // A bit just switched to input is reloaded this cycle and kept out of the compare.
  assign newly_input = TRISB[7:4] & ~trisb_hi_prev;
  assign mismatch    = (PORTB_q[7:4] ^ snapshot) & TRISB[7:4] & ~newly_input;
  assign int_edge    = OPTION[OPT_INTEDG] ? (~rb0_prev & PORTB_q[0])
                                          : (rb0_prev & ~PORTB_q[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot      <= '0;
      trisb_hi_prev <= '0;
      rb0_prev      <= 1'b0;
      mismatch_prev <= 1'b0;
      INTF_set      <= 1'b0;
      RBIF_set      <= 1'b0;
    end else begin
      rb0_prev      <= PORTB_q[0];
      trisb_hi_prev <= TRISB[7:4];
      INTF_set      <= (state == ARMED) && TRISB[0] && int_edge;
      if (arm_done || ((state == ARMED) && (PORTB_rd || PORTB_wr))) begin
        snapshot      <= PORTB_q[7:4];
        mismatch_prev <= 1'b0;
        RBIF_set      <= 1'b0;
      end else if (state != ARMED) begin
        mismatch_prev <= 1'b0;
        RBIF_set      <= 1'b0;
      end else begin
        snapshot      <= (snapshot & ~newly_input) | (PORTB_q[7:4] & newly_input);
        mismatch_prev <= |mismatch;
        RBIF_set      <= (|mismatch) && !mismatch_prev;
      end
    end
  end

endmodule
